// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for a shared write port: registered winner index plus decoded one-hot grant.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int SEL_W    = 3,
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4,
  localparam int N       = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             valid_nxt;

  if ((2**CNT_W) <= HOLD_MAX) begin : g_cnt_w_too_small
    $error("CNT_W too narrow for HOLD_MAX");
  end

  // First requester after the last winner, wrapping; the last winner itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] cand;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = last + SEL_W'(i);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt   = rr_pick(req, gnt_idx);
          valid_nxt = 1'b1;
          state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        if (done || !req[gnt_idx]) begin
          state_nxt = GAP;
        end else begin
`ifdef ARB_TIMEOUT_EN
          // cnt holds completed grant cycles; this cycle would be number HOLD_MAX.
          if (cnt == CNT_W'(HOLD_MAX - 1)) begin
            state_nxt   = GAP;
            timeout_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b1;
            cnt_nxt   = cnt + 1'b1;
          end
`else
          valid_nxt = 1'b1;
`endif
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= SEL_W'(N - 1);
      gnt_valid <= 1'b0;
      gnt       <= '0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= valid_nxt ? decode(idx_nxt) : '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
